// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute-stage ALU: op codes, FSM state encoding, control width.
package alu_pkg;

  localparam int ALU_CW = 4;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle over WIDTH cycles.
// lo_next/hi_next are the values after the current step, so the caller can capture the final step directly.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  logic [CNTW-1:0]  cnt;
  logic             div_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_try;
  logic             take;

  assign busy = (cnt != '0);
  assign done = (cnt == CNTW'(1));

  // Multiply: hi accumulates, lo holds the multiplier shifting out LSB-first.
  // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rem_try = {hi_q, lo_q[WIDTH-1]};
    take    = (rem_try >= {1'b0, opnd_q});
    if (div_q) begin
      hi_next = take ? (rem_try[WIDTH-1:0] - opnd_q) : rem_try[WIDTH-1:0];
      lo_next = {lo_q[WIDTH-2:0], take};
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      div_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (start) begin
      cnt    <= CNTW'(WIDTH);
      div_q  <= is_div;
      hi_q   <= '0;
      lo_q   <= is_div ? a : b;
      opnd_q <= is_div ? b : a;
    end else if (busy) begin
      cnt  <= cnt - CNTW'(1);
      hi_q <= hi_next;
      lo_q <= lo_next;
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Clocked execute-stage ALU with valid/ready handshake and registered results.
// Optional iterative MULTU/DIVU enabled by defining ALU_MULDIV_EN.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = ALU_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [CW-1:0]    iALUctrl,
  output logic             oReady,
  output logic             oValid,
  output logic [WIDTH-1:0] oRes,
  output logic [WIDTH-1:0] oHi,
  output logic             oZero,
  output logic             oDivZero,
  output state_t           oState
);

  // Handshake: a request transfers on a rising edge where iValid && oReady; the
  // requester holds it while oReady is low, and oValid pulses once per accepted op.

  localparam logic [CW-1:0] OP_AND = CW'(ALU_AND);
  localparam logic [CW-1:0] OP_OR  = CW'(ALU_OR);
  localparam logic [CW-1:0] OP_ADD = CW'(ALU_ADD);
  localparam logic [CW-1:0] OP_XOR = CW'(ALU_XOR);
  localparam logic [CW-1:0] OP_SUB = CW'(ALU_SUB);
  localparam logic [CW-1:0] OP_SLT = CW'(ALU_SLT);
  localparam logic [CW-1:0] OP_NOR = CW'(ALU_NOR);

  state_t           state;
  logic             accept;
  logic [WIDTH-1:0] comb_res;
  logic [WIDTH-1:0] comb_hi;

  assign oState = state;
  assign oReady = (state == S_IDLE) || (state == S_DONE);
  assign accept = iValid && oReady;

`ifdef ALU_MULDIV_EN
  localparam logic [CW-1:0] OP_MULTU = CW'(ALU_MULTU);
  localparam logic [CW-1:0] OP_DIVU  = CW'(ALU_DIVU);

  logic             is_mul;
  logic             is_div;
  logic             md_start;
  logic             md_busy;
  logic             md_done;
  logic [WIDTH-1:0] md_lo;
  logic [WIDTH-1:0] md_hi;
  logic             zero_q;
  logic             div_zero_q;

  assign is_mul   = (iALUctrl == OP_MULTU);
  assign is_div   = (iALUctrl == OP_DIVU);
  // Divide by zero skips iteration and resolves on the single-cycle path.
  assign md_start = accept && (is_mul || (is_div && (iB != '0)));
  assign oDivZero = div_zero_q;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start),
    .is_div  (is_div),
    .a       (iA),
    .b       (iB),
    .busy    (md_busy),
    .done    (md_done),
    .lo_next (md_lo),
    .hi_next (md_hi)
  );
`else
  assign oDivZero = 1'b0;
`endif

  always_comb begin
    comb_res = '0;
    comb_hi  = '0;
    case (iALUctrl)
      OP_ADD:  comb_res = iA + iB;
      OP_SUB:  comb_res = iA - iB;
      OP_AND:  comb_res = iA & iB;
      OP_OR:   comb_res = iA | iB;
      OP_XOR:  comb_res = iA ^ iB;
      OP_NOR:  comb_res = ~(iA | iB);
      OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, (iA < iB)};
`ifdef ALU_MULDIV_EN
      OP_DIVU: begin
        comb_res = '1;
        comb_hi  = iA;
      end
`endif
      default: begin
        comb_res = '0;
        comb_hi  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      oValid <= 1'b0;
      oRes   <= '0;
      oHi    <= '0;
      oZero  <= 1'b0;
`ifdef ALU_MULDIV_EN
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      oValid <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (md_start) begin
              state  <= is_div ? S_DIV : S_MUL;
              zero_q <= (iA == iB);
            end else
`endif
            begin
              state  <= S_DONE;
              oValid <= 1'b1;
              oRes   <= comb_res;
              oHi    <= comb_hi;
              oZero  <= (iA == iB);
`ifdef ALU_MULDIV_EN
              div_zero_q <= is_div;
`endif
            end
          end
        end
`ifdef ALU_MULDIV_EN
        S_MUL, S_DIV: begin
          // A lost busy also exits, so the FSM can never stall here.
          if (md_done || !md_busy) begin
            state      <= S_DONE;
            oValid     <= 1'b1;
            oRes       <= md_lo;
            oHi        <= md_hi;
            oZero      <= zero_q;
            div_zero_q <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed self-checking bench for alu_seq_exec: a 32-bit and an 8-bit instance.
// Expected values follow whether ALU_MULDIV_EN is defined for the build.
module tb_alu_seq_exec;
  import alu_pkg::*;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        v32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [3:0]  c32 = '0;
  logic        rdy32, val32, zero32, dz32;
  logic [31:0] res32, hi32;
  state_t      st32;

  logic        v8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  c8 = '0;
  logic        rdy8, val8, zero8, dz8;
  logic [7:0]  res8, hi8;
  state_t      st8;

  alu_seq_exec #(.WIDTH(32), .CW(4)) dut32 (
    .clk(clk), .rst(rst), .iValid(v32), .iA(a32), .iB(b32), .iALUctrl(c32),
    .oReady(rdy32), .oValid(val32), .oRes(res32), .oHi(hi32), .oZero(zero32),
    .oDivZero(dz32), .oState(st32)
  );

  alu_seq_exec #(.WIDTH(8), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .iValid(v8), .iA(a8), .iB(b8), .iALUctrl(c8),
    .oReady(rdy8), .oValid(val8), .oRes(res8), .oHi(hi8), .oZero(zero8),
    .oDivZero(dz8), .oState(st8)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // driver: one op on the 32-bit unit; pokes iValid while busy and scrambles operands
  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                       input logic [31:0] exp_hi, input logic exp_zero, input logic exp_dz,
                       input int exp_busy);
    int lat;
    int busy;
    lat  = 0;
    busy = 0;
    @(negedge clk);
    v32 = 1'b1; c32 = op; a32 = a; b32 = b;
    @(posedge clk);
    #1;
    v32 = 1'b0; c32 = ALU_ADD; a32 = $urandom; b32 = $urandom;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (val32) break;
      if (!rdy32) busy++;
      v32 = !rdy32 && lat[0];
    end
    v32 = 1'b0;
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, 64'(res32), 64'(exp_res));
    check({tag, ".hi"}, 64'(hi32), 64'(exp_hi));
    check({tag, ".zero"}, 64'(zero32), 64'(exp_zero));
    check({tag, ".divzero"}, 64'(dz32), 64'(exp_dz));
    check({tag, ".busy_cycles"}, 64'(busy), 64'(exp_busy));
    @(negedge clk);
    check({tag, ".pulse"}, 64'(val32), 64'd0);
    check({tag, ".ready_after"}, 64'(rdy32), 64'd1);
  endtask

  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res,
                      input logic [7:0] exp_hi);
    int lat;
    lat = 0;
    @(negedge clk);
    v8 = 1'b1; c8 = op; a8 = a; b8 = b;
    @(posedge clk);
    #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (val8) break;
    end
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".res"}, 64'(res8), 64'(exp_res));
    check({tag, ".hi"}, 64'(hi8), 64'(exp_hi));
  endtask

  initial begin
    logic [3:0]  b2b_op [3];
    logic [31:0] b2b_a  [3];
    logic [31:0] b2b_b  [3];
    int valids;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset.ready", 64'(rdy32), 64'd1);
    check("reset.valid", 64'(val32), 64'd0);
    check("reset.res", 64'(res32), 64'd0);
    check("reset.hi", 64'(hi32), 64'd0);
    check("reset.zero", 64'(zero32), 64'd0);
    check("reset.divzero", 64'(dz32), 64'd0);
    check("reset.state", 64'(st32), 64'(S_IDLE));

    // back-to-back: request held high across DONE cycles
    b2b_op = '{ALU_ADD, ALU_SUB, ALU_SLT};
    b2b_a  = '{32'd7, 32'd5, 32'd3};
    b2b_b  = '{32'd5, 32'd7, 32'd9};
    exp_q.push_back(32'd12);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        check($sformatf("b2b%0d.valid", k - 1), 64'(val32), 64'd1);
        check($sformatf("b2b%0d.res", k - 1), 64'(res32), 64'(exp_q.pop_front()));
        check($sformatf("b2b%0d.zero", k - 1), 64'(zero32), 64'd0);
      end
      if (k < 3) begin
        v32 = 1'b1; c32 = b2b_op[k]; a32 = b2b_a[k]; b32 = b2b_b[k];
      end else begin
        v32 = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b.end_pulse", 64'(val32), 64'd0);

    // single-cycle ops
    run32("add_eq",  ALU_ADD, 32'd4, 32'd4, 1, 32'd8, 0, 1'b1, 1'b0, 0);
    run32("and",     ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 0, 1'b0, 1'b0, 0);
    run32("or",      ALU_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'hFFF0_FF34, 0, 1'b0, 1'b0, 0);
    run32("xor",     ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'hFF00_ED34, 0, 1'b0, 1'b0, 0);
    run32("nor",     ALU_NOR, 32'h0000_FFFF, 32'h00FF_0000, 1, 32'hFF00_0000, 0, 1'b0, 1'b0, 0);
    run32("slt_gt",  ALU_SLT, 32'd9, 32'd3, 1, 32'd0, 0, 1'b0, 1'b0, 0);
    run32("slt_eq",  ALU_SLT, 32'd5, 32'd5, 1, 32'd0, 0, 1'b1, 1'b0, 0);
    run32("slt_big", ALU_SLT, 32'd1, 32'h8000_0000, 1, 32'd1, 0, 1'b0, 1'b0, 0);
    run32("sub_wrap", ALU_SUB, 32'd0, 32'd1, 1, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 0);
    run32("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 0, 1'b0, 1'b0, 0);
    run32("unknown", 4'b1111, 32'd3, 32'd4, 1, 32'd0, 0, 1'b0, 1'b0, 0);

    // multiply / divide
    if (MD) begin
      run32("mul_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0, 32);
      run32("mul_3x4", ALU_MULTU, 32'd3, 32'd4, 33, 32'd12, 32'd0, 1'b0, 1'b0, 32);
      run32("div_100_7", ALU_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0, 32);
      run32("div_by0", ALU_DIVU, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, 32'd100, 1'b0, 1'b1, 0);
    end else begin
      run32("mul_max", ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd0, 32'd0, 1'b1, 1'b0, 0);
      run32("mul_3x4", ALU_MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd0, 1'b0, 1'b0, 0);
      run32("div_100_7", ALU_DIVU, 32'd100, 32'd7, 1, 32'd0, 32'd0, 1'b0, 1'b0, 0);
      run32("div_by0", ALU_DIVU, 32'd100, 32'd0, 1, 32'd0, 32'd0, 1'b0, 1'b0, 0);
    end
    run32("after_div0", ALU_ADD, 32'd1, 32'd2, 1, 32'd3, 0, 1'b0, 1'b0, 0);

    // 8-bit instance
    if (MD) begin
      run8("w8_mul", ALU_MULTU, 8'hFF, 8'h02, 9, 8'hFE, 8'h01);
      run8("w8_div", ALU_DIVU, 8'hFF, 8'h10, 9, 8'h0F, 8'h0F);
    end else begin
      run8("w8_mul", ALU_MULTU, 8'hFF, 8'h02, 1, 8'h00, 8'h00);
      run8("w8_div", ALU_DIVU, 8'hFF, 8'h10, 1, 8'h00, 8'h00);
    end
    run8("w8_unknown", 4'b1111, 8'h12, 8'h34, 1, 8'h00, 8'h00);
    run8("w8_add", ALU_ADD, 8'hF0, 8'h20, 1, 8'h10, 8'h00);

    // reset in the middle of a multiply, after a nonzero result
    run32("pre_rst", ALU_ADD, 32'd7, 32'd5, 1, 32'd12, 0, 1'b0, 1'b0, 0);
    @(negedge clk);
    v32 = 1'b1; c32 = ALU_MULTU; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.ready", 64'(rdy32), 64'd1);
    check("rst_mid.valid", 64'(val32), 64'd0);
    check("rst_mid.res", 64'(res32), 64'd0);
    check("rst_mid.hi", 64'(hi32), 64'd0);
    check("rst_mid.state", 64'(st32), 64'(S_IDLE));
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (val32) valids++;
    end
    check("rst_mid.no_late_valid", 64'(valids), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
